mixer_scheduler: RTL and testbench

MIXER_SCHEDULER -- requirements
Module: mixer_scheduler

---
 rtl/mixer_scheduler.sv | 173 +++++++++++++++++
 tb/tb_mixer_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixer_scheduler.sv
// Round-robin scheduler sharing one Mixer among CHANNELS requesters, each with a one-entry holding slot.
// Optional WAIT watchdog abort is built when MIXER_SCHEDULER_TIMEOUT_EN is defined.
package mixer_scheduler_pkg;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IQ_W   = 18;

    typedef struct packed {
        logic              Valid;
        logic [DATA_W-1:0] Data;
    } DataStream;

    typedef struct packed {
        logic            Valid;
        logic [IQ_W-1:0] I;
        logic [IQ_W-1:0] Q;
    } ComplexStream;
endpackage

module mixer_scheduler
    import mixer_scheduler_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                        ipClk,
    input  logic                        ipReset,
    input  DataStream [CHANNELS-1:0]    ipInput,
    output logic [CHANNELS-1:0]         opReady,
    output DataStream                   opMixInput,
    input  ComplexStream                ipMixOutput,
    output ComplexStream                opOutput,
    output logic [$clog2(CHANNELS)-1:0] opChannel,
    output logic                        opBusy,
    output logic                        opTimeout
);
    localparam int unsigned CH_W = $clog2(CHANNELS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]        state, nextState;
    logic [CH_W-1:0]   ptr, ptrNext;
    logic [CH_W-1:0]   grantIdx, grantNext;
    logic [CH_W-1:0]   rrIdx, rrCand;
    logic              rrFound;
    logic [CHANNELS-1:0] loadMask, readyNext;
    logic [DATA_W-1:0] slotData [CHANNELS];
    DataStream         mixNext;
    ComplexStream      outNext;
    logic [CH_W-1:0]   chanNext;
    logic              timeoutNext;

`ifdef MIXER_SCHEDULER_TIMEOUT_EN
    logic [7:0]        waitCnt, cntNext;
`else
    logic [7:0]        unusedTimeout;
    assign unusedTimeout = 8'(TIMEOUT);
`endif

    // Holding slots: a load is accepted only while the slot is empty (opReady high)
    for (genvar g = 0; g < CHANNELS; g++) begin : gSlot
        assign loadMask[g] = ipInput[g].Valid & opReady[g];

        always_ff @(posedge ipClk or negedge ipReset) begin
            if (!ipReset) begin
                slotData[g] <= '0;
            end else if (loadMask[g]) begin
                slotData[g] <= ipInput[g].Data;
            end
        end
    end

    // Round-robin search starting just after the last granted requester
    always_comb begin
        rrFound = 1'b0;
        rrIdx   = '0;
        rrCand  = '0;
        for (int k = 1; k <= int'(CHANNELS); k++) begin
            rrCand = CH_W'((int'(ptr) + k) % int'(CHANNELS));
            if (!rrFound && !opReady[rrCand]) begin
                rrFound = 1'b1;
                rrIdx   = rrCand;
            end
        end
    end

    always_comb begin
        nextState     = state;
        ptrNext       = ptr;
        grantNext     = grantIdx;
        readyNext     = opReady & ~loadMask;
        mixNext       = opMixInput;
        mixNext.Valid = 1'b0;
        outNext       = opOutput;
        outNext.Valid = 1'b0;
        chanNext      = opChannel;
        timeoutNext   = 1'b0;
`ifdef MIXER_SCHEDULER_TIMEOUT_EN
        cntNext       = waitCnt;
`endif
        case (state)
            IDLE: begin
                if (rrFound) begin
                    nextState     = ISSUE;
                    ptrNext       = rrIdx;
                    grantNext     = rrIdx;
                    mixNext.Valid = 1'b1;
                    mixNext.Data  = slotData[rrIdx];
                end
            end
            ISSUE: begin
                nextState           = WAIT;
                readyNext[grantIdx] = 1'b1;
`ifdef MIXER_SCHEDULER_TIMEOUT_EN
                cntNext             = 8'd0;
`endif
            end
            WAIT: begin
                if (ipMixOutput.Valid) begin
                    nextState     = IDLE;
                    outNext.Valid = 1'b1;
                    outNext.I     = ipMixOutput.I;
                    outNext.Q     = ipMixOutput.Q;
                    chanNext      = grantIdx;
                end
`ifdef MIXER_SCHEDULER_TIMEOUT_EN
                else if (waitCnt == 8'(TIMEOUT - 1)) begin
                    nextState   = IDLE;
                    timeoutNext = 1'b1;
                end else begin
                    cntNext = waitCnt + 8'd1;
                end
`endif
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state      <= IDLE;
            ptr        <= CH_W'(CHANNELS - 1);
            grantIdx   <= '0;
            opReady    <= '1;
            opMixInput <= '0;
            opOutput   <= '0;
            opChannel  <= '0;
            opBusy     <= 1'b0;
            opTimeout  <= 1'b0;
        end else begin
            state      <= nextState;
            ptr        <= ptrNext;
            grantIdx   <= grantNext;
            opReady    <= readyNext;
            opMixInput <= mixNext;
            opOutput   <= outNext;
            opChannel  <= chanNext;
            opBusy     <= (nextState != IDLE);
            opTimeout  <= timeoutNext;
        end
    end

`ifdef MIXER_SCHEDULER_TIMEOUT_EN
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            waitCnt <= 8'd0;
        end else begin
            waitCnt <= cntNext;
        end
    end
`endif
endmodule

// File: tb/tb_mixer_scheduler.sv
// Scoreboard bench for mixer_scheduler: stimulus queues expected issues/outputs, a monitor pops and compares.
module tb_mixer_scheduler;
    import mixer_scheduler_pkg::*;

    localparam int unsigned CH = 4;
    localparam int unsigned TO = 15;
    localparam int unsigned CW = 2;

    typedef struct {
        logic [17:0]   i;
        logic [17:0]   q;
        logic [CW-1:0] ch;
    } ExpOut;

    logic               ipClk;
    logic               ipReset;
    DataStream [CH-1:0] ipInput;
    logic [CH-1:0]      opReady;
    DataStream          opMixInput;
    ComplexStream       ipMixOutput;
    ComplexStream       opOutput;
    logic [CW-1:0]      opChannel;
    logic               opBusy;
    logic               opTimeout;

    logic [15:0] expIssue[$];
    ExpOut       expOut[$];
    ExpOut       monExp;
    int          checks = 0;
    int          passes = 0;
    int          firstTo;
    int          pulses;
    logic        busyAt;

    mixer_scheduler #(.CHANNELS(CH), .TIMEOUT(TO)) dut (
        .ipClk       (ipClk),
        .ipReset     (ipReset),
        .ipInput     (ipInput),
        .opReady     (opReady),
        .opMixInput  (opMixInput),
        .ipMixOutput (ipMixOutput),
        .opOutput    (opOutput),
        .opChannel   (opChannel),
        .opBusy      (opBusy),
        .opTimeout   (opTimeout)
    );

    initial ipClk = 1'b0;
    always #5 ipClk = ~ipClk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    endtask

    // Monitor: every issue and every output must match the head of its queue
    always @(negedge ipClk) begin
        if (ipReset === 1'b1) begin
            if (opMixInput.Valid) begin
                if (expIssue.size() == 0) check("unexpected_issue", 64'(opMixInput.Valid), 64'd0);
                else check("issue_data", 64'(opMixInput.Data), 64'(expIssue.pop_front()));
            end
            if (opOutput.Valid) begin
                if (expOut.size() == 0) begin
                    check("unexpected_output", 64'(opOutput.Valid), 64'd0);
                end else begin
                    monExp = expOut.pop_front();
                    check("out_i", 64'(opOutput.I), 64'(monExp.i));
                    check("out_q", 64'(opOutput.Q), 64'(monExp.q));
                    check("out_channel", 64'(opChannel), 64'(monExp.ch));
                end
            end
        end
    end

    task automatic pushExp(input logic [15:0] d, input logic [17:0] i, input logic [17:0] q,
                           input logic [CW-1:0] ch);
        ExpOut e;
        e.i = i;
        e.q = q;
        e.ch = ch;
        expIssue.push_back(d);
        expOut.push_back(e);
    endtask

    task automatic doReset();
        ipReset     = 1'b0;
        ipInput     = '0;
        ipMixOutput = '0;
        repeat (2) @(negedge ipClk);
        ipReset = 1'b1;
        @(negedge ipClk);
    endtask

    task automatic loadCh(input logic [CW-1:0] ch, input logic [15:0] d);
        ipInput[ch].Valid = 1'b1;
        ipInput[ch].Data  = d;
        @(negedge ipClk);
        ipInput[ch] = '0;
    endtask

    task automatic mixReturn(input logic [17:0] i, input logic [17:0] q);
        ipMixOutput.Valid = 1'b1;
        ipMixOutput.I     = i;
        ipMixOutput.Q     = q;
        @(negedge ipClk);
        ipMixOutput = '0;
    endtask

    task automatic waitIssue();
        int t = 0;
        while (!opMixInput.Valid && t < 100) begin
            @(negedge ipClk);
            t++;
        end
        if (!opMixInput.Valid) check("issue_seen", 64'(opMixInput.Valid), 64'd1);
    endtask

    task automatic mixRespond(input logic [17:0] i, input logic [17:0] q);
        waitIssue();
        @(negedge ipClk);
        mixReturn(i, q);
    endtask

    task automatic checkCleared(input string tag);
        check({tag, "_ready"}, 64'(opReady), 64'hF);
        check({tag, "_busy"}, 64'(opBusy), 64'd0);
        check({tag, "_mixin"}, 64'(opMixInput), 64'd0);
        check({tag, "_output"}, 64'(opOutput), 64'd0);
        check({tag, "_channel"}, 64'(opChannel), 64'd0);
        check({tag, "_timeout"}, 64'(opTimeout), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete, passed=%0d total=%0d", passes, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ipReset     = 1'b0;
        ipInput     = '0;
        ipMixOutput = '0;
        repeat (3) @(negedge ipClk);
        checkCleared("reset");
        ipReset = 1'b1;
        @(negedge ipClk);

        // Single sample on channel 2
        pushExp(16'h4000, 18'h10000, 18'h3FFFF, 2'd2);
        loadCh(2'd2, 16'h4000);
        check("ready_drop", 64'(opReady), 64'hB);
        mixRespond(18'h10000, 18'h3FFFF);
        repeat (3) @(negedge ipClk);
        check("ready_restore", 64'(opReady), 64'hF);

        // All four full after reset, channel 0 refilled while channel 1 is served
        doReset();
        for (int k = 0; k < 4; k++)
            pushExp(16'(16'hA000 + k), 18'(18'h01001 + k), 18'(18'h2F001 + k), CW'(k));
        pushExp(16'hB000, 18'h0B000, 18'h1B000, 2'd0);
        ipInput[0] = '{Valid: 1'b1, Data: 16'hA000};
        ipInput[1] = '{Valid: 1'b1, Data: 16'hA001};
        ipInput[2] = '{Valid: 1'b1, Data: 16'hA002};
        ipInput[3] = '{Valid: 1'b1, Data: 16'hA003};
        @(negedge ipClk);
        ipInput = '0;
        mixRespond(18'h01001, 18'h2F001);
        loadCh(2'd0, 16'hB000);
        for (int k = 1; k < 4; k++) mixRespond(18'(18'h01001 + k), 18'(18'h2F001 + k));
        mixRespond(18'h0B000, 18'h1B000);
        repeat (3) @(negedge ipClk);
        check("contention_ready", 64'(opReady), 64'hF);

        // Overrun: channel 1 presents Valid on three consecutive cycles
        pushExp(16'h1111, 18'h2AAAA, 18'h15555, 2'd1);
        ipInput[1] = '{Valid: 1'b1, Data: 16'h1111};
        @(negedge ipClk);
        ipInput[1].Data = 16'h2222;
        @(negedge ipClk);
        ipInput[1].Data = 16'h3333;
        @(negedge ipClk);
        ipInput[1] = '0;
        check("overrun_busy", 64'(opBusy), 64'd1);
        mixReturn(18'h2AAAA, 18'h15555);
        repeat (4) @(negedge ipClk);
        check("overrun_ready", 64'(opReady), 64'hF);
        check("overrun_idle", 64'(opBusy), 64'd0);

        // Stray Mixer return while idle
        mixReturn(18'h12345, 18'h00ABC);
        check("stray_busy", 64'(opBusy), 64'd0);
        check("stray_out", 64'(opOutput.Valid), 64'd0);
        repeat (2) @(negedge ipClk);

        // Reset during WAIT, then a late Mixer return
        expIssue.push_back(16'h7777);
        loadCh(2'd2, 16'h7777);
        waitIssue();
        @(negedge ipClk);
        check("wait_busy", 64'(opBusy), 64'd1);
        ipReset = 1'b0;
        repeat (2) @(negedge ipClk);
        checkCleared("midwait");
        ipReset = 1'b1;
        @(negedge ipClk);
        mixReturn(18'h1F00F, 18'h0F0F1);
        repeat (2) @(negedge ipClk);
        check("late_busy", 64'(opBusy), 64'd0);
        check("late_ready", 64'(opReady), 64'hF);

        // Mixer silent on channel 0 with channel 1 pending
        expIssue.push_back(16'h0A0A);
`ifndef MIXER_SCHEDULER_TIMEOUT_EN
        begin
            ExpOut e;
            e.i = 18'h00A0A;
            e.q = 18'h3F5F5;
            e.ch = 2'd0;
            expOut.push_back(e);
        end
`endif
        pushExp(16'h0B0B, 18'h00B0B, 18'h3F4F4, 2'd1);
        ipInput[0] = '{Valid: 1'b1, Data: 16'h0A0A};
        ipInput[1] = '{Valid: 1'b1, Data: 16'h0B0B};
        @(negedge ipClk);
        ipInput = '0;
        waitIssue();
        firstTo = 0;
        pulses  = 0;
        busyAt  = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            @(negedge ipClk);
            if (opTimeout) begin
                pulses++;
                if (firstTo == 0) begin
                    firstTo = n;
                    busyAt  = opBusy;
                end
            end
        end
`ifdef MIXER_SCHEDULER_TIMEOUT_EN
        check("timeout_cycle", 64'(firstTo), 64'd16);
        check("timeout_pulses", 64'(pulses), 64'd1);
        check("timeout_idle", 64'(busyAt), 64'd0);
`else
        check("no_timeout_pulses", 64'(pulses), 64'd0);
        check("wait_holds", 64'(opBusy), 64'd1);
        mixReturn(18'h00A0A, 18'h3F5F5);
`endif
        mixRespond(18'h00B0B, 18'h3F4F4);

        repeat (5) @(negedge ipClk);
        check("issue_queue_empty", 64'(expIssue.size()), 64'd0);
        check("output_queue_empty", 64'(expOut.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
